// File: rtl/execute_stage.sv
// ============================================================================
// execute_stage : single-issue execute stage, 8-op ALU with valid/ready handshake.
// Optional shift-add multiplier for op 7 when MULTIPLIER_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module execute_stage #(
   parameter int DATA_WIDTH        = 32,
   parameter int REGADDR_WIDTH     = 5,
   parameter int RESLT_SELCT_WIDTH = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        aOperand_in,
   input  logic [DATA_WIDTH-1:0]        bOperand_in,
   input  logic [DATA_WIDTH-1:0]        immediateVal_in,
   input  logic                         immediateSelect_in,
   input  logic                         unsignedSelect_in,
   input  logic                         subtractEnable_in,
   input  logic [RESLT_SELCT_WIDTH-1:0] resultSelect_in,
   input  logic [REGADDR_WIDTH-1:0]     writeSelect_in,
   input  logic                         writeEnable_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_WIDTH-1:0]        result_out,
   output logic [REGADDR_WIDTH-1:0]     writeSelect_out,
   output logic                         writeEnable_out,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int c_SHAMT_W = $clog2(DATA_WIDTH);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_DONE     = 2'd2;
`ifdef MULTIPLIER_EN
   localparam logic [1:0] c_MUL_BUSY = 2'd1;
   localparam int         c_CNT_W    = c_SHAMT_W + 1;
`endif

   logic [1:0]               r_state;
   logic [DATA_WIDTH-1:0]    r_result;
   logic [REGADDR_WIDTH-1:0] r_wsel;
   logic                     r_wen;

   logic                     w_accept;
   logic                     w_is_mul;
   logic [DATA_WIDTH-1:0]    w_b;
   logic [c_SHAMT_W-1:0]     w_shamt;
   logic                     w_lt;
   logic [DATA_WIDTH-1:0]    w_sra;
   logic [DATA_WIDTH-1:0]    w_alu;

   assign in_ready = (r_state == c_IDLE) || ((r_state == c_DONE) && out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_is_mul = (resultSelect_in == 3'd7);

   assign out_valid       = (r_state == c_DONE);
   assign result_out      = r_result;
   assign writeSelect_out = r_wsel;
   assign writeEnable_out = r_wen;

   assign w_b     = immediateSelect_in ? immediateVal_in : bOperand_in;
   assign w_shamt = w_b[c_SHAMT_W-1:0];
   assign w_lt    = unsignedSelect_in ? (aOperand_in < w_b)
                                      : ($signed(aOperand_in) < $signed(w_b));
   assign w_sra   = $unsigned($signed(aOperand_in) >>> w_shamt);

   always_comb begin
      w_alu = '0;
      case (resultSelect_in)
         3'd0:    w_alu = subtractEnable_in ? (aOperand_in - w_b) : (aOperand_in + w_b);
         3'd1:    w_alu = aOperand_in & w_b;
         3'd2:    w_alu = aOperand_in | w_b;
         3'd3:    w_alu = aOperand_in ^ w_b;
         3'd4:    w_alu = {{(DATA_WIDTH-1){1'b0}}, w_lt};
         3'd5:    w_alu = aOperand_in << w_shamt;
         3'd6:    w_alu = unsignedSelect_in ? (aOperand_in >> w_shamt) : w_sra;
         default: w_alu = '0;
      endcase
   end

`ifdef MULTIPLIER_EN
   logic [DATA_WIDTH-1:0] r_mcand;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [c_CNT_W-1:0]    r_cnt;
   logic [DATA_WIDTH-1:0] w_acc_next;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= c_IDLE;
         r_result <= '0;
         r_wsel   <= '0;
         r_wen    <= 1'b0;
`ifdef MULTIPLIER_EN
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
`endif
      end else if (w_accept) begin
         r_wsel <= writeSelect_in;
`ifdef MULTIPLIER_EN
         r_wen  <= writeEnable_in;
         if (w_is_mul) begin
            r_state  <= c_MUL_BUSY;
            r_mcand  <= aOperand_in;
            r_mplier <= w_b;
            r_acc    <= '0;
            r_cnt    <= '0;
         end else begin
            r_state  <= c_DONE;
            r_result <= w_alu;
         end
`else
         // op 7 has no hardware here: completes as a no-write zero result
         r_state  <= c_DONE;
         r_result <= w_alu;
         r_wen    <= writeEnable_in && !w_is_mul;
`endif
      end else if ((r_state == c_DONE) && out_ready) begin
         r_state <= c_IDLE;
      end
`ifdef MULTIPLIER_EN
      // DATA_WIDTH add/shift steps, then one more edge to publish the product
      else if (r_state == c_MUL_BUSY) begin
         if (r_cnt == c_CNT_W'(DATA_WIDTH)) begin
            r_state  <= c_DONE;
            r_result <= r_acc;
         end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
         end
      end
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// tb_execute_stage : directed self-checking bench for execute_stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] aOperand_in, bOperand_in, immediateVal_in;
   logic        immediateSelect_in, unsignedSelect_in, subtractEnable_in;
   logic [2:0]  resultSelect_in;
   logic [4:0]  writeSelect_in;
   logic        writeEnable_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result_out;
   logic [4:0]  writeSelect_out;
   logic        writeEnable_out;
   logic        out_valid;
   logic        out_ready;

   int n_cmp = 0;
   int n_err = 0;

   execute_stage #(
      .DATA_WIDTH(32), .REGADDR_WIDTH(5), .RESLT_SELCT_WIDTH(3)
   ) dut (
      .clk(clk), .reset(reset),
      .aOperand_in(aOperand_in), .bOperand_in(bOperand_in), .immediateVal_in(immediateVal_in),
      .immediateSelect_in(immediateSelect_in), .unsignedSelect_in(unsignedSelect_in),
      .subtractEnable_in(subtractEnable_in), .resultSelect_in(resultSelect_in),
      .writeSelect_in(writeSelect_in), .writeEnable_in(writeEnable_in),
      .in_valid(in_valid), .in_ready(in_ready),
      .result_out(result_out), .writeSelect_out(writeSelect_out),
      .writeEnable_out(writeEnable_out), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic isel, input logic uns,
                          input logic sub, input logic [4:0] ws, input logic we);
      resultSelect_in    = op;
      aOperand_in        = a;
      bOperand_in        = b;
      immediateVal_in    = imm;
      immediateSelect_in = isel;
      unsignedSelect_in  = uns;
      subtractEnable_in  = sub;
      writeSelect_in     = ws;
      writeEnable_in     = we;
   endtask

   // Present one instruction for one edge from IDLE, leaving out_ready low.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic isel, input logic uns,
                        input logic sub, input logic [4:0] ws, input logic we);
      set_ins(op, a, b, imm, isel, uns, sub, ws, we);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      n_cmp++; if (result_out !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h want 0", result_out); end
      n_cmp++; if (writeSelect_out !== 5'd0) begin n_err++; $display("FAIL rst_wsel: got %0d want 0", writeSelect_out); end
      n_cmp++; if (writeEnable_out !== 1'b0) begin n_err++; $display("FAIL rst_wen: got %b want 0", writeEnable_out); end
      reset = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      do_op(3'd0, 32'd5, 32'd0, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
      n_cmp++; if (result_out !== 32'h0) begin n_err++; $display("FAIL add_result: got %h want 0", result_out); end
      n_cmp++; if (writeSelect_out !== 5'd3) begin n_err++; $display("FAIL add_wsel: got %0d want 3", writeSelect_out); end
      n_cmp++; if (writeEnable_out !== 1'b1) begin n_err++; $display("FAIL add_wen: got %b want 1", writeEnable_out); end
      drain();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_idle_valid: got %b want 0", out_valid); end
      do_op(3'd0, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
      n_cmp++; if (result_out !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_result: got %h want fffffffe", result_out); end
      drain();
   endtask

   task automatic test_logic();
      do_op(3'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
      n_cmp++; if (result_out !== 32'h00F0_1200) begin n_err++; $display("FAIL and_result: got %h want 00f01200", result_out); end
      drain();
      do_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
      n_cmp++; if (result_out !== 32'hFFF0_FF34) begin n_err++; $display("FAIL or_result: got %h want fff0ff34", result_out); end
      drain();
      do_op(3'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
      n_cmp++; if (result_out !== 32'hFF00_ED34) begin n_err++; $display("FAIL xor_result: got %h want ff00ed34", result_out); end
      drain();
   endtask

   task automatic test_slt();
      do_op(3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
      n_cmp++; if (result_out !== 32'd1) begin n_err++; $display("FAIL slt_signed: got %h want 1", result_out); end
      drain();
      do_op(3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
      n_cmp++; if (result_out !== 32'd0) begin n_err++; $display("FAIL slt_unsigned: got %h want 0", result_out); end
      drain();
   endtask

   task automatic test_shift();
      do_op(3'd5, 32'd1, 32'h0000_0024, 32'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
      n_cmp++; if (result_out !== 32'h10) begin n_err++; $display("FAIL sll_result: got %h want 00000010", result_out); end
      drain();
      do_op(3'd6, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
      n_cmp++; if (result_out !== 32'hF800_0000) begin n_err++; $display("FAIL sra_result: got %h want f8000000", result_out); end
      drain();
      do_op(3'd6, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1);
      n_cmp++; if (result_out !== 32'h0800_0000) begin n_err++; $display("FAIL srl_result: got %h want 08000000", result_out); end
      drain();
   endtask

   task automatic test_stall_back_to_back();
      do_op(3'd0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
      set_ins(3'd3, 32'hFF, 32'h0F, 32'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (result_out !== 32'd30 || writeSelect_out !== 5'd7 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL stall_hold[%0d]: got %h/%0d/%b want 1e/7/1", i, result_out, writeSelect_out, out_valid); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (result_out !== 32'hF0 || writeSelect_out !== 5'd9 || out_valid !== 1'b1)
         begin n_err++; $display("FAIL b2b_result: got %h/%0d/%b want f0/9/1", result_out, writeSelect_out, out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_in_done();
      do_op(3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
      reset = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || result_out !== 32'h0 || writeSelect_out !== 5'd0 || writeEnable_out !== 1'b0)
         begin n_err++; $display("FAIL rst_done: got %b/%h/%0d/%b want 0/0/0/0", out_valid, result_out, writeSelect_out, writeEnable_out); end
      tick();
      reset = 1'b1;
      do_op(3'd0, 32'd7, 32'd8, 32'd0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
      n_cmp++; if (result_out !== 32'd15 || out_valid !== 1'b1)
         begin n_err++; $display("FAIL rst_done_recover: got %h/%b want f/1", result_out, out_valid); end
      drain();
   endtask

`ifdef MULTIPLIER_EN
   task automatic test_mul();
      int cycles;
      do_op(3'd7, 32'h0001_0001, 32'h0001_0001, 32'd0, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1);
      set_ins(3'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
      in_valid = 1'b1;
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 40) begin
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_in_ready[%0d]: got %b want 0", cycles, in_ready); end
         tick();
         cycles++;
      end
      in_valid = 1'b0;
      n_cmp++; if (cycles !== 33) begin n_err++; $display("FAIL mul_latency: got %0d want 33", cycles); end
      n_cmp++; if (result_out !== 32'h0002_0001 || writeSelect_out !== 5'd11 || writeEnable_out !== 1'b1)
         begin n_err++; $display("FAIL mul_result: got %h/%0d/%b want 00020001/11/1", result_out, writeSelect_out, writeEnable_out); end
      drain();
   endtask

   task automatic test_reset_mid_mul();
      do_op(3'd7, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || result_out !== 32'h0 || writeSelect_out !== 5'd0 || writeEnable_out !== 1'b0)
         begin n_err++; $display("FAIL rst_mul: got %b/%h/%0d/%b want 0/0/0/0", out_valid, result_out, writeSelect_out, writeEnable_out); end
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mul_abort: got %b want 0", out_valid); end
      do_op(3'd0, 32'd7, 32'd8, 32'd0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
      n_cmp++; if (result_out !== 32'd15 || out_valid !== 1'b1)
         begin n_err++; $display("FAIL rst_mul_recover: got %h/%b want f/1", result_out, out_valid); end
      drain();
   endtask
`else
   task automatic test_op7_disabled();
      do_op(3'd7, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 5'd13, 1'b1);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL op7_valid: got %b want 1", out_valid); end
      n_cmp++; if (result_out !== 32'h0) begin n_err++; $display("FAIL op7_result: got %h want 0", result_out); end
      n_cmp++; if (writeEnable_out !== 1'b0) begin n_err++; $display("FAIL op7_wen: got %b want 0", writeEnable_out); end
      drain();
   endtask
`endif

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_ins(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      tick();
      test_reset();
      test_add();
      test_logic();
      test_slt();
      test_shift();
      test_stall_back_to_back();
      test_reset_in_done();
`ifdef MULTIPLIER_EN
      test_mul();
      test_reset_mid_mul();
`else
      test_op7_disabled();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 aOperand_in, bOperand_in, immediateVal_in  input  DATA_WIDTH  operands from the decoded-instruction frame register.
REQ-005 immediateSelect_in, unsignedSelect_in, subtractEnable_in  input  1 each  operand B source, signedness and subtract controls.
REQ-006 resultSelect_in  input  RESLT_SELCT_WIDTH (3)  operation select.
REQ-007 writeSelect_in  input  REGADDR_WIDTH  destination register; writeEnable_in  input  1  writeback request.
REQ-008 in_valid  input  1  frame holds a valid instruction; in_ready  output  1  stage accepts this cycle.
REQ-009 result_out  output  DATA_WIDTH  registered result; writeSelect_out  output  REGADDR_WIDTH; writeEnable_out  output  1.
REQ-010 out_valid  output  1  result held valid; out_ready  input  1  writeback consumes the result.

Function
REQ-011 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-012 Operand B SHALL be immediateVal_in when immediateSelect_in=1, else bOperand_in.
REQ-013 Encodings SHALL be: 0 add (subtract when subtractEnable_in=1), 1 AND, 2 OR, 3 XOR, 4 set-less-than, 5 shift left logical, 6 shift right, 7 multiply.
REQ-014 Add/sub SHALL wrap modulo 2^DATA_WIDTH with no overflow flag.
REQ-015 Set-less-than SHALL compare unsigned when unsignedSelect_in=1, signed otherwise, and return 1 or 0.
REQ-016 Shift amount SHALL be B[log2(DATA_WIDTH)-1:0]; shift right SHALL be logical when unsignedSelect_in=1, arithmetic otherwise.
REQ-017 The FSM SHALL have states IDLE, MUL_BUSY and DONE.
REQ-018 Accept of ops 0-6 SHALL go to DONE with result_out, writeSelect_out and writeEnable_out registered on that same edge (latency 1).
REQ-019 Accept of op 7 (multiplier compiled in) SHALL go to MUL_BUSY, run a shift-add multiply for DATA_WIDTH cycles, then enter DONE with the low DATA_WIDTH bits of the product (out_valid after DATA_WIDTH+1 cycles).
REQ-020 In MUL_BUSY, in_ready SHALL be 0 and upstream inputs SHALL be ignored; operands SHALL be captured at accept.
REQ-021 In DONE, out_valid SHALL be 1 and all outputs SHALL be held stable until out_ready=1.
REQ-022 DONE with out_ready=1 and no accept SHALL go to IDLE with out_valid=0.
REQ-023 DONE with out_ready=1 and a simultaneous accept SHALL load the new instruction on that edge (back-to-back, no bubble).
REQ-024 out_valid SHALL never be 1 in IDLE or MUL_BUSY.

Reset
REQ-025 reset=0 SHALL asynchronously force state=IDLE, out_valid=0, result_out=0, writeSelect_out=0, writeEnable_out=0 and clear the multiply accumulator and counter.
REQ-026 Reset asserted during MUL_BUSY or DONE SHALL abort the instruction with no result delivered.
REQ-027 After reset release, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-028 Macro MULTIPLIER_EN SHALL compile the multiplier in: MUL_BUSY, the accumulator and the iteration counter exist, and op 7 behaves per REQ-019.
REQ-029 Without MULTIPLIER_EN, op 7 SHALL complete with latency 1, result_out=0 and writeEnable_out=0, and no MUL_BUSY state or multiplier logic SHALL exist.

Verification
REQ-030 Bench SHALL cover: add A=5, imm=0xFFFFFFFB, immediateSelect=1 -> result_out=0 after 1 cycle, out_valid=1.
REQ-031 Bench SHALL cover: set-less-than A=0xFFFFFFFF, B=1 -> 1 with unsignedSelect=0 and 0 with unsignedSelect=1; shift right A=0x80000000, B=4 -> 0xF8000000 arithmetic, 0x08000000 logical.
REQ-032 Bench SHALL cover, with MULTIPLIER_EN: multiply 0x10001 x 0x10001 -> 0x00020001 with out_valid rising 33 cycles after accept and in_ready=0 throughout.
REQ-033 Bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 -> the next result appears the following cycle.
REQ-034 Bench SHALL cover: reset=0 asserted mid-multiply -> out_valid=0 and all outputs 0 immediately; after release, a new add completes normally.
REQ-035 Bench SHALL cover, without MULTIPLIER_EN: op 7 -> result_out=0, writeEnable_out=0, latency 1.
